// File: rtl/logic_unit_seq.sv
// Registered bitwise logic unit: one operation per valid/ready transfer, a
// one-deep output register, an accumulator for chaining and an op counter.
module logic_unit_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    input  logic             acc,
    input  logic             clr_acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] acc_q,
    output logic [CNT_W-1:0] op_cnt
);

    logic             accept;
    logic [WIDTH-1:0] op_a_p0;
    logic [WIDTH-1:0] res_p0;

    // sel 000/001 are the legacy OR/NOR pair; every code maps to an op.
    function automatic logic [WIDTH-1:0] logic_op(
        input logic [WIDTH-1:0] op_a,
        input logic [WIDTH-1:0] op_b,
        input logic [2:0]       op_sel
    );
        case (op_sel)
            3'b000:  logic_op = op_a | op_b;
            3'b001:  logic_op = ~(op_a | op_b);
            3'b010:  logic_op = op_a & op_b;
            3'b011:  logic_op = ~(op_a & op_b);
            3'b100:  logic_op = op_a ^ op_b;
            3'b101:  logic_op = ~(op_a ^ op_b);
            3'b110:  logic_op = ~op_a;
            default: logic_op = op_b;
        endcase
    endfunction

    // Ready depends only on the output register state, never on in_valid.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign op_a_p0  = acc ? acc_q : a;
    assign res_p0   = logic_op(op_a_p0, b, sel);

    // Stage p0 -> p1: result, accumulator and counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            s         <= '0;
            acc_q     <= '0;
            op_cnt    <= '0;
        end else begin
            if (accept) begin
                s         <= res_p0;
                out_valid <= 1'b1;
                op_cnt    <= op_cnt + CNT_W'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // Clear wins over a same-cycle result; the operand already used the old value.
            if (clr_acc) begin
                acc_q <= '0;
            end else if (accept) begin
                acc_q <= res_p0;
            end
        end
    end

endmodule

// File: tb/tb_logic_unit_seq.sv
// Bench for logic_unit_seq: directed scenarios plus random traffic checked
// against a cycle-level transaction model built from per-bit truth tables.
module tb_logic_unit_seq;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] sel;
    logic       acc;
    logic       clr_acc;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] s;
    logic [7:0] acc_q;
    logic [3:0] op_cnt;

    logic       l_valid;
    logic       l_ready;
    logic [0:0] l_a;
    logic [0:0] l_b;
    logic [2:0] l_sel;
    logic       l_out_valid;
    logic [0:0] l_s;
    logic [0:0] l_acc_q;
    logic [3:0] l_op_cnt;

    int errors = 0;
    int checks = 0;

    logic [7:0] m_s   = '0;
    logic       m_vld = 1'b0;
    logic [7:0] m_acc = '0;
    logic [3:0] m_cnt = '0;

    logic_unit_seq #(.WIDTH(8), .CNT_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sel(sel), .acc(acc), .clr_acc(clr_acc),
        .out_valid(out_valid), .out_ready(out_ready), .s(s),
        .acc_q(acc_q), .op_cnt(op_cnt)
    );

    logic_unit_seq #(.WIDTH(1), .CNT_W(4)) u_leg (
        .clk(clk), .rst_n(rst_n), .in_valid(l_valid), .in_ready(l_ready),
        .a(l_a), .b(l_b), .sel(l_sel), .acc(1'b0), .clr_acc(1'b0),
        .out_valid(l_out_valid), .out_ready(1'b1), .s(l_s),
        .acc_q(l_acc_q), .op_cnt(l_op_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Truth table per op, indexed by {a_bit, b_bit}.
    function automatic logic [3:0] truth(input logic [2:0] op);
        case (op)
            3'd0:    truth = 4'b1110;
            3'd1:    truth = 4'b0001;
            3'd2:    truth = 4'b1000;
            3'd3:    truth = 4'b0111;
            3'd4:    truth = 4'b0110;
            3'd5:    truth = 4'b1001;
            3'd6:    truth = 4'b0011;
            default: truth = 4'b1010;
        endcase
    endfunction

    function automatic logic [7:0] ref_op(input logic [7:0] x, input logic [7:0] y,
                                          input logic [2:0] op);
        logic [3:0] tt;
        logic [7:0] r;
        tt = truth(op);
        for (int i = 0; i < 8; i++) r[i] = tt[{x[i], y[i]}];
        return r;
    endfunction

    // Advance one clock edge, moving the model by the transfer rules.
    task automatic step();
        logic [7:0] nx_s, nx_acc, op_a, r;
        logic       nx_vld;
        logic [3:0] nx_cnt;
        nx_s = m_s; nx_vld = m_vld; nx_acc = m_acc; nx_cnt = m_cnt;
        if (!rst_n) begin
            nx_s = '0; nx_vld = 1'b0; nx_acc = '0; nx_cnt = '0;
        end else begin
            if (in_valid && (!m_vld || out_ready)) begin
                op_a   = acc ? m_acc : a;
                r      = ref_op(op_a, b, sel);
                nx_s   = r;
                nx_vld = 1'b1;
                nx_acc = r;
                nx_cnt = 4'((int'(m_cnt) + 1) % 16);
            end else if (out_ready) begin
                nx_vld = 1'b0;
            end
            if (clr_acc) nx_acc = '0;
        end
        @(posedge clk);
        #1;
        m_s = nx_s; m_vld = nx_vld; m_acc = nx_acc; m_cnt = nx_cnt;
    endtask

    task automatic idle();
        in_valid = 1'b0; a = '0; b = '0; sel = '0; acc = 1'b0; clr_acc = 1'b0;
        out_ready = 1'b1; l_valid = 1'b0; l_a = '0; l_b = '0; l_sel = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0; in_valid = 1'b1; a = 8'hFF; b = 8'h00; sel = 3'b000;
        l_valid = 1'b1; l_a = 1'b1; l_b = 1'b1;
        step();
        step();
        checks++;
        if (s !== 8'h00 || out_valid !== 1'b0 || acc_q !== 8'h00 || op_cnt !== 4'h0)
            begin errors++; $display("FAIL reset_state: s=%h vld=%b acc=%h cnt=%h, want 00 0 00 0", s, out_valid, acc_q, op_cnt); end
        checks++;
        if (l_s !== 1'b0 || l_out_valid !== 1'b0 || l_op_cnt !== 4'h0)
            begin errors++; $display("FAIL reset_legacy: s=%b vld=%b cnt=%h, want 0 0 0", l_s, l_out_valid, l_op_cnt); end
        rst_n = 1'b1;
        idle();
        #1;
        checks++;
        if (in_ready !== 1'b1 || op_cnt !== 4'h0)
            begin errors++; $display("FAIL reset_release: in_ready=%b cnt=%h, want 1 0", in_ready, op_cnt); end
    endtask

    task automatic test_legacy();
        logic [0:0] exp_or, exp_nor;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            l_a = 1'(i >> 1); l_b = 1'(i & 1);
            exp_or  = l_a | l_b;
            exp_nor = ~(l_a | l_b);
            l_valid = 1'b1; l_sel = 3'b000;
            step();
            checks++;
            if (l_s !== exp_or || l_out_valid !== 1'b1)
                begin errors++; $display("FAIL legacy_or a=%b b=%b: s=%b vld=%b, want %b 1", l_a, l_b, l_s, l_out_valid, exp_or); end
            l_sel = 3'b001;
            step();
            checks++;
            if (l_s !== exp_nor || l_out_valid !== 1'b1)
                begin errors++; $display("FAIL legacy_nor a=%b b=%b: s=%b vld=%b, want %b 1", l_a, l_b, l_s, l_out_valid, exp_nor); end
        end
        l_valid = 1'b0;
        step();
        checks++;
        if (l_op_cnt !== 4'd8 || l_out_valid !== 1'b0 || l_acc_q !== l_s)
            begin errors++; $display("FAIL legacy_end: cnt=%h vld=%b acc=%b, want 8 0 %b", l_op_cnt, l_out_valid, l_acc_q, l_s); end
    endtask

    task automatic test_all_ops();
        logic [7:0] exp_tab [8];
        exp_tab = '{8'hDE, 8'h21, 8'h48, 8'hB7, 8'h96, 8'h69, 8'h35, 8'h5C};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; a = 8'hCA; b = 8'h5C; sel = 3'(i);
            step();
            checks++;
            if (s !== exp_tab[i] || s !== m_s || out_valid !== 1'b1)
                begin errors++; $display("FAIL all_ops sel=%0d: s=%h vld=%b, want %h 1", i, s, out_valid, exp_tab[i]); end
        end
        idle();
        checks++;
        if (op_cnt !== 4'd8)
            begin errors++; $display("FAIL all_ops_cnt: cnt=%0d, want 8", op_cnt); end
    endtask

    task automatic test_backpressure();
        do_reset();
        in_valid = 1'b1; a = 8'h0F; b = 8'hF0; sel = 3'b000;
        step();
        out_ready = 1'b0; a = 8'h33; b = 8'h0F; sel = 3'b010;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (s !== 8'hFF || out_valid !== 1'b1 || in_ready !== 1'b0 || op_cnt !== 4'd1 || acc_q !== 8'hFF)
                begin errors++; $display("FAIL backpressure_hold %0d: s=%h vld=%b rdy=%b cnt=%0d acc=%h, want FF 1 0 1 FF", i, s, out_valid, in_ready, op_cnt, acc_q); end
            step();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1)
            begin errors++; $display("FAIL backpressure_release_rdy: rdy=%b, want 1", in_ready); end
        step();
        checks++;
        if (s !== 8'h03 || out_valid !== 1'b1 || op_cnt !== 4'd2)
            begin errors++; $display("FAIL backpressure_next: s=%h vld=%b cnt=%0d, want 03 1 2", s, out_valid, op_cnt); end
        idle();
        step();
        checks++;
        if (out_valid !== 1'b0 || s !== 8'h03 || op_cnt !== 4'd2)
            begin errors++; $display("FAIL backpressure_drain: vld=%b s=%h cnt=%0d, want 0 03 2", out_valid, s, op_cnt); end
    endtask

    task automatic test_acc_chain();
        logic [7:0] exp_seq [3];
        exp_seq = '{8'h01, 8'h00, 8'h01};
        idle();
        clr_acc = 1'b1;
        step();
        checks++;
        if (acc_q !== 8'h00)
            begin errors++; $display("FAIL acc_clear: acc=%h, want 00", acc_q); end
        clr_acc = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; acc = 1'b1; a = 8'hA5; b = 8'h01; sel = 3'b100;
            step();
            checks++;
            if (s !== exp_seq[i] || acc_q !== exp_seq[i])
                begin errors++; $display("FAIL acc_chain %0d: s=%h acc=%h, want %h", i, s, acc_q, exp_seq[i]); end
        end
        clr_acc = 1'b1;
        step();
        checks++;
        if (s !== 8'h00 || acc_q !== 8'h00 || out_valid !== 1'b1)
            begin errors++; $display("FAIL acc_clear_accept: s=%h acc=%h vld=%b, want 00 00 1", s, acc_q, out_valid); end
        idle();
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom); sel = 3'($urandom);
            step();
            if (i == 15) begin
                checks++;
                if (op_cnt !== 4'hF)
                    begin errors++; $display("FAIL cnt_15: cnt=%h, want F", op_cnt); end
            end
            if (i == 16) begin
                checks++;
                if (op_cnt !== 4'h0)
                    begin errors++; $display("FAIL cnt_16: cnt=%h, want 0", op_cnt); end
            end
            if (i == 17) begin
                checks++;
                if (op_cnt !== 4'h1 || s !== m_s)
                    begin errors++; $display("FAIL cnt_17: cnt=%h s=%h, want 1 %h", op_cnt, s, m_s); end
            end
        end
        idle();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst_n     = ($urandom_range(0, 63) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            a = 8'($urandom); b = 8'($urandom); sel = 3'($urandom);
            acc = ($urandom_range(0, 1) != 0);
            clr_acc = ($urandom_range(0, 7) == 0);
            #1;
            checks++;
            if (in_ready !== (!m_vld || out_ready))
                begin errors++; $display("FAIL rand_ready %0d: rdy=%b, want %b", i, in_ready, (!m_vld || out_ready)); end
            step();
            checks++;
            if (s !== m_s || out_valid !== m_vld || acc_q !== m_acc || op_cnt !== m_cnt)
                begin errors++; $display("FAIL rand_state %0d: s=%h vld=%b acc=%h cnt=%h, want %h %b %h %h", i, s, out_valid, acc_q, op_cnt, m_s, m_vld, m_acc, m_cnt); end
        end
        rst_n = 1'b1;
        idle();
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        #1;
        test_reset();
        test_legacy();
        test_all_ops();
        test_backpressure();
        test_acc_chain();
        test_counter_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
